// File: rtl/fifo_sync_prog_if.sv
// Handshake and status bundle for fifo_sync_prog.
// slave  : the FIFO side (takes requests, drives data/status)
// master : the producer/consumer side
interface fifo_sync_prog_if #(
  parameter int data_width    = 8,
  parameter int address_width = 4
);
  logic [data_width-1:0]  wr_data;
  logic                   w_inc;
  logic                   r_inc;
  logic [address_width:0] af_thresh;
  logic [address_width:0] ae_thresh;
  logic                   clr_err;
  logic [data_width-1:0]  rd_data;
  logic                   rd_valid;
  logic                   full;
  logic                   empty;
  logic                   almost_full;
  logic                   almost_empty;
  logic [address_width:0] fill_level;
  logic                   overflow;
  logic                   underflow;

  modport slave (
    input  wr_data, w_inc, r_inc, af_thresh, ae_thresh, clr_err,
    output rd_data, rd_valid, full, empty, almost_full, almost_empty,
           fill_level, overflow, underflow
  );

  modport master (
    output wr_data, w_inc, r_inc, af_thresh, ae_thresh, clr_err,
    input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
           fill_level, overflow, underflow
  );
endinterface

// File: rtl/fifo_sync_prog.sv
// Single-clock FIFO with programmable almost-full/almost-empty thresholds,
// exact fill level and sticky overflow/underflow flags.
// Optional build macro FIFO_SYNC_FWFT_EN selects first-word-fall-through read
// behaviour; when undefined, reads have one cycle of latency.
// All status flags are registered from the next fill level, so they change
// on the same edge as fill_level.
module fifo_sync_prog #(
  parameter int data_width    = 8,
  parameter int address_width = 4
) (
  input logic             clk,
  input logic             rst,
  fifo_sync_prog_if.slave bus
);
  localparam int DEPTH = 2 ** address_width;
  localparam logic [address_width:0] C_DEPTH = (address_width + 1)'(DEPTH);
  localparam logic [address_width:0] C_ONE   = (address_width + 1)'(1);
  localparam logic [address_width:0] C_ZERO  = '0;

  logic [data_width-1:0]  r_mem [DEPTH];
  logic [address_width:0] r_wr_ptr;
  logic [address_width:0] r_rd_ptr;
  logic [address_width:0] r_fill;
  logic                   r_full;
  logic                   r_empty;
  logic                   r_af;
  logic                   r_ae;
  logic                   r_ovf;
  logic                   r_unf;
  logic [data_width-1:0]  r_rd_data;
  logic                   r_rd_valid;

  logic                   w_rd_acc;
  logic                   w_wr_acc;
  logic [address_width:0] w_fill_nxt;
  logic [address_width:0] w_rd_ptr_nxt;
  logic [address_width:0] w_wr_ptr_nxt;

  // Acceptance: a read needs data; a write needs room, or a same-cycle read
  // that frees a slot.
  always_comb begin
    w_rd_acc     = bus.r_inc && !r_empty;
    w_wr_acc     = bus.w_inc && (!r_full || w_rd_acc);
    w_rd_ptr_nxt = w_rd_acc ? r_rd_ptr + C_ONE : r_rd_ptr;
    w_wr_ptr_nxt = w_wr_acc ? r_wr_ptr + C_ONE : r_wr_ptr;
    w_fill_nxt   = r_fill;
    if (w_wr_acc && !w_rd_acc) begin
      w_fill_nxt = r_fill + C_ONE;
    end else if (w_rd_acc && !w_wr_acc) begin
      w_fill_nxt = r_fill - C_ONE;
    end
  end

  // Storage array; not reset, contents only meaningful between pointers.
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[r_wr_ptr[address_width-1:0]] <= bus.wr_data;
    end
  end

  // Pointers, fill level, registered status flags and sticky errors.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_fill   <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_af     <= 1'b0;
      r_ae     <= 1'b1;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
    end else begin
      r_wr_ptr <= w_wr_ptr_nxt;
      r_rd_ptr <= w_rd_ptr_nxt;
      r_fill   <= w_fill_nxt;
      r_full   <= (w_fill_nxt == C_DEPTH);
      r_empty  <= (w_fill_nxt == C_ZERO);
      r_af     <= (w_fill_nxt >= bus.af_thresh);
      r_ae     <= (w_fill_nxt <= bus.ae_thresh);
      // A fresh error in the clearing cycle keeps the flag set.
      r_ovf    <= (bus.w_inc && !w_wr_acc) || (r_ovf && !bus.clr_err);
      r_unf    <= (bus.r_inc && r_empty)   || (r_unf && !bus.clr_err);
    end
  end

`ifdef FIFO_SYNC_FWFT_EN
  // Head register: presents the next head word; a word becoming head in the
  // same cycle it is written is taken straight from wr_data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= (w_fill_nxt != C_ZERO);
      if (w_fill_nxt != C_ZERO) begin
        if (w_wr_acc && (w_rd_ptr_nxt == r_wr_ptr)) begin
          r_rd_data <= bus.wr_data;
        end else begin
          r_rd_data <= r_mem[w_rd_ptr_nxt[address_width-1:0]];
        end
      end
    end
  end
`else
  // Standard read port: popped word appears one edge after acceptance.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_acc;
      if (w_rd_acc) begin
        r_rd_data <= r_mem[r_rd_ptr[address_width-1:0]];
      end
    end
  end
`endif

  assign bus.rd_data      = r_rd_data;
  assign bus.rd_valid     = r_rd_valid;
  assign bus.full         = r_full;
  assign bus.empty        = r_empty;
  assign bus.almost_full  = r_af;
  assign bus.almost_empty = r_ae;
  assign bus.fill_level   = r_fill;
  assign bus.overflow     = r_ovf;
  assign bus.underflow    = r_unf;

endmodule

// File: tb/tb_fifo_sync_prog.sv
// Self-checking bench for fifo_sync_prog: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
// Build with FIFO_SYNC_FWFT_EN defined to exercise the fall-through mode.
module tb_fifo_sync_prog;
  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;

  fifo_sync_prog_if #(.data_width(DW), .address_width(AW)) bus ();

  fifo_sync_prog #(.data_width(DW), .address_width(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model state
  int       q[$];
  int       m_rd_data;
  bit       m_rd_valid;
  bit       m_ovf;
  bit       m_unf;
  bit       m_af;
  bit       m_ae;
  int       af_thr;
  int       ae_thr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL %s at %0t: got %0h want %0h", tag, $time, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_rd_data  = 0;
    m_rd_valid = 1'b0;
    m_ovf      = 1'b0;
    m_unf      = 1'b0;
    m_af       = 1'b0;
    m_ae       = 1'b1;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".fill"},  32'(bus.fill_level),   32'(q.size()));
    chk({tag, ".full"},  32'(bus.full),         32'(q.size() == DEPTH));
    chk({tag, ".empty"}, 32'(bus.empty),        32'(q.size() == 0));
    chk({tag, ".af"},    32'(bus.almost_full),  32'(m_af));
    chk({tag, ".ae"},    32'(bus.almost_empty), 32'(m_ae));
    chk({tag, ".ovf"},   32'(bus.overflow),     32'(m_ovf));
    chk({tag, ".unf"},   32'(bus.underflow),    32'(m_unf));
    chk({tag, ".vld"},   32'(bus.rd_valid),     32'(m_rd_valid));
    chk({tag, ".data"},  32'(bus.rd_data),      32'(m_rd_data));
  endtask

  // One clock: drive inputs, advance model by the FIFO rules, check after edge.
  task automatic cycle(input string tag, input bit w, input bit r, input int d, input bit clr);
    bit rd_acc;
    bit wr_acc;
    bus.w_inc     = w;
    bus.r_inc     = r;
    bus.wr_data   = DW'(d);
    bus.clr_err   = clr;
    bus.af_thresh = (AW + 1)'(af_thr);
    bus.ae_thresh = (AW + 1)'(ae_thr);
    rd_acc = r && (q.size() > 0);
    wr_acc = w && ((q.size() < DEPTH) || rd_acc);
    m_ovf  = (w && !wr_acc) || (m_ovf && !clr);
    m_unf  = (r && q.size() == 0) || (m_unf && !clr);
`ifdef FIFO_SYNC_FWFT_EN
    if (rd_acc) void'(q.pop_front());
    if (wr_acc) q.push_back(d & 8'hFF);
    if (q.size() > 0) m_rd_data = q[0];
    m_rd_valid = (q.size() > 0);
`else
    if (rd_acc) m_rd_data = q.pop_front();
    m_rd_valid = rd_acc;
    if (wr_acc) q.push_back(d & 8'hFF);
`endif
    m_af = (q.size() >= af_thr);
    m_ae = (q.size() <= ae_thr);
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    int pw;
    int pr;
    bus.w_inc     = 1'b0;
    bus.r_inc     = 1'b0;
    bus.wr_data   = '0;
    bus.clr_err   = 1'b0;
    af_thr        = 12;
    ae_thr        = 3;
    bus.af_thresh = 5'd12;
    bus.ae_thresh = 5'd3;
    model_reset();
    #12;
    check_all("reset");
    rst = 1'b1;

    // mid-traffic asynchronous reset
    for (int i = 0; i < 5; i++) cycle("pre_rst", 1'b1, 1'b0, 8'h40 + i, 1'b0);
    #3;
    rst = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    #2;
    rst = 1'b1;

    // fill to full, thresholds crossed on the way, then drain in order
    for (int i = 0; i < DEPTH; i++) cycle("fill", 1'b1, 1'b0, i, 1'b0);
    chk("full_after_16", 32'(bus.full), 32'd1);
    // overflow: write while full, 0xAA must never appear
    cycle("ovf", 1'b1, 1'b0, 8'hAA, 1'b0);
    cycle("ovf_hold", 1'b0, 1'b0, 0, 1'b0);
    cycle("ovf_clr", 1'b0, 1'b0, 0, 1'b1);
    // full + simultaneous read/write keeps level, exercises wrap
    for (int i = 0; i < 5; i++) cycle("full_rw", 1'b1, 1'b1, 8'hB0 + i, 1'b0);
    for (int i = 0; i < DEPTH; i++) cycle("drain", 1'b0, 1'b1, 0, 1'b0);
    cycle("idle", 1'b0, 1'b0, 0, 1'b0);

    // underflow with simultaneous write
    cycle("unf_w", 1'b1, 1'b1, 8'h5C, 1'b0);
    cycle("rd_5c", 1'b0, 1'b1, 0, 1'b0);
    cycle("after", 1'b0, 1'b0, 0, 1'b0);
    // error raised in the clearing cycle wins
    cycle("unf_clr", 1'b0, 1'b1, 0, 1'b1);
    cycle("unf_clr2", 1'b0, 1'b0, 0, 1'b1);

    // threshold corners
    af_thr = 0;
    ae_thr = 16;
    cycle("thr_corner", 1'b1, 1'b0, 8'h11, 1'b0);
    af_thr = 12;
    ae_thr = 3;

    // randomized traffic
    pw = 50;
    pr = 50;
    for (int i = 0; i < 2000; i++) begin
      if (i % 100 == 0) begin
        case ($urandom_range(0, 2))
          0: begin pw = 80; pr = 30; end
          1: begin pw = 30; pr = 80; end
          default: begin pw = 50; pr = 50; end
        endcase
        af_thr = $urandom_range(0, 18);
        ae_thr = $urandom_range(0, 18);
      end
      cycle("rand",
            $urandom_range(0, 99) < pw,
            $urandom_range(0, 99) < pr,
            $urandom_range(0, 255),
            $urandom_range(0, 19) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
